// File: rtl/mips_pkg.sv
// Shared constants for the MIPS data-side memory map.
// Region tags, MMIO register offsets and TIMER_CTRL bit positions.
package mips_pkg;

    localparam logic [15:0] RAM_BASE_HI  = 16'h0000;
    localparam logic [15:0] MMIO_BASE_HI = 16'hFFFF;

    localparam logic [7:0] OFS_GPIO  = 8'h00;
    localparam logic [7:0] OFS_CYCLE = 8'h04;
    localparam logic [7:0] OFS_TCMP  = 8'h08;
    localparam logic [7:0] OFS_TCTRL = 8'h0C;

    localparam int unsigned TCTRL_EN   = 0;
    localparam int unsigned TCTRL_FLAG = 1;

    typedef enum logic [1:0] {
        RegionNone,
        RegionRam,
        RegionMmio
    } region_e;

    // Classify an access by the upper half of its byte address.
    function automatic region_e decode_region(input logic [15:0] addr_hi);
        if (addr_hi == RAM_BASE_HI) begin
            return RegionRam;
        end
        if (addr_hi == MMIO_BASE_HI) begin
            return RegionMmio;
        end
        return RegionNone;
    endfunction

endpackage

// File: rtl/mmio_timer.sv
// Compare timer: TIMER_CMP, TIMER_CTRL (EN, FLAG) and the internal TIMER_COUNT.
// Only instantiated when DMEM_TIMER_EN is defined.
module mmio_timer
    import mips_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        i_cmp_we,
    input  logic        i_ctrl_we,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_cmp,
    output logic [31:0] o_ctrl,
    output logic        o_irq
);

    logic [31:0] r_cmp;
    logic [31:0] r_count;
    logic        r_en;
    logic        r_flag;
    logic        w_match;

    // Match is only meaningful while the timer is enabled.
    always_comb begin
        w_match = r_en && (r_count == r_cmp);
    end

    // Timer state; a hardware FLAG set wins over a W1C, and a CMP write zeroes the count.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cmp   <= '0;
            r_count <= '0;
            r_en    <= 1'b0;
            r_flag  <= 1'b0;
        end else begin
            if (i_cmp_we) begin
                r_cmp <= i_wdata;
            end
            if (i_ctrl_we) begin
                r_en <= i_wdata[TCTRL_EN];
            end
            if (w_match) begin
                r_flag <= 1'b1;
            end else if (i_ctrl_we && i_wdata[TCTRL_FLAG]) begin
                r_flag <= 1'b0;
            end
            if (i_cmp_we || w_match) begin
                r_count <= '0;
            end else if (r_en) begin
                r_count <= r_count + 32'd1;
            end
        end
    end

    // Register readback; unused TIMER_CTRL bits read as 0.
    always_comb begin
        o_cmp             = r_cmp;
        o_ctrl            = '0;
        o_ctrl[TCTRL_EN]   = r_en;
        o_ctrl[TCTRL_FLAG] = r_flag;
        o_irq             = r_flag;
    end

endmodule

// File: rtl/data_memory.sv
// Data-side memory responder: word RAM plus an MMIO window (GPIO, CYCLE, timer).
// Define DMEM_TIMER_EN to build the compare timer; otherwise its registers read 0.
module data_memory
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              mem_write,
    input  logic [31:0]       address,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    output logic [DATA_W-1:0] gpio_out,
    output logic              timer_irq
);

    localparam int unsigned AW = $clog2(DEPTH);

    region_e           w_region;
    logic [7:0]        w_ofs;
    logic [AW-1:0]     w_idx;
    logic              w_ram_we;
    logic              w_gpio_we;
    logic [DATA_W-1:0] w_tcmp;
    logic [DATA_W-1:0] w_tctrl;
    logic              w_unused_addr;

    logic [DATA_W-1:0] r_ram [DEPTH];
    logic [DATA_W-1:0] r_gpio;
    logic [DATA_W-1:0] r_cycle;

    // Byte lane bits and high RAM offset bits are don't-care; RAM aliases modulo DEPTH.
    assign w_region      = decode_region(address[31:16]);
    assign w_ofs         = address[7:0];
    assign w_idx         = address[AW+1:2];
    assign w_unused_addr = ^address;

    assign w_ram_we  = mem_write && (w_region == RegionRam);
    assign w_gpio_we = mem_write && (w_region == RegionMmio) && (w_ofs == OFS_GPIO);

    // RAM is not reset; stores are suppressed while reset is asserted.
    always_ff @(posedge clock) begin
        if (w_ram_we && reset_n) begin
            r_ram[w_idx] <= write_data;
        end
    end

    // GPIO output register and free-running cycle counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_gpio  <= '0;
            r_cycle <= '0;
        end else begin
            if (w_gpio_we) begin
                r_gpio <= write_data;
            end
            r_cycle <= r_cycle + 1'b1;
        end
    end

    assign gpio_out = r_gpio;

`ifdef DMEM_TIMER_EN
    logic w_tcmp_we;
    logic w_tctrl_we;

    assign w_tcmp_we  = mem_write && (w_region == RegionMmio) && (w_ofs == OFS_TCMP);
    assign w_tctrl_we = mem_write && (w_region == RegionMmio) && (w_ofs == OFS_TCTRL);

    mmio_timer u_timer (
        .clock     (clock),
        .reset_n   (reset_n),
        .i_cmp_we  (w_tcmp_we),
        .i_ctrl_we (w_tctrl_we),
        .i_wdata   (write_data),
        .o_cmp     (w_tcmp),
        .o_ctrl    (w_tctrl),
        .o_irq     (timer_irq)
    );
`else
    assign w_tcmp    = '0;
    assign w_tctrl   = '0;
    assign timer_irq = 1'b0;
`endif

    // Combinational load path: a same-cycle store is not yet visible.
    always_comb begin
        read_data = '0;
        unique case (w_region)
            RegionRam: read_data = r_ram[w_idx];
            RegionMmio: begin
                case (w_ofs)
                    OFS_GPIO:  read_data = r_gpio;
                    OFS_CYCLE: read_data = r_cycle;
                    OFS_TCMP:  read_data = w_tcmp;
                    OFS_TCTRL: read_data = w_tctrl;
                    default:   read_data = '0;
                endcase
            end
            default: read_data = '0;
        endcase
    end

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed scenarios then random traffic
// against a behavioural model of the memory map. Timer checks follow DMEM_TIMER_EN.
module tb_data_memory;

    localparam int unsigned DEPTH = 256;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        mem_write;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic [31:0] gpio_out;
    logic        timer_irq;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model of the architectural state.
    logic [31:0] m_mem [int];
    logic [31:0] m_gpio;
    logic [31:0] m_cycle;
    logic [31:0] m_cmp;
    logic [31:0] m_count;
    logic        m_en;
    logic        m_flag;

    data_memory #(
        .DEPTH  (DEPTH),
        .DATA_W (32)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .mem_write  (mem_write),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .gpio_out   (gpio_out),
        .timer_irq  (timer_irq)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_gpio  = '0;
        m_cycle = '0;
        m_cmp   = '0;
        m_count = '0;
        m_en    = 1'b0;
        m_flag  = 1'b0;
    endtask

    function automatic logic exp_irq();
`ifdef DMEM_TIMER_EN
        return m_flag;
`else
        return 1'b0;
`endif
    endfunction

    // Expected load value; returns 0 when the RAM word was never written by the bench.
    function automatic logic exp_read(input logic [31:0] a, output logic [31:0] v);
        int k;
        v = '0;
        if (a[31:16] == 16'h0000) begin
            k = int'((a >> 2) % DEPTH);
            if (!m_mem.exists(k)) return 1'b0;
            v = m_mem[k];
        end else if (a[31:16] == 16'hFFFF) begin
            case (a[7:0])
                8'h00: v = m_gpio;
                8'h04: v = m_cycle;
`ifdef DMEM_TIMER_EN
                8'h08: v = m_cmp;
                8'h0C: v = {30'b0, m_flag, m_en};
`endif
                default: v = '0;
            endcase
        end
        return 1'b1;
    endfunction

    // Advance the model across one rising edge using the inputs presented this cycle.
    task automatic model_edge();
        logic        mmio;
        logic        match;
        logic        cmp_w;
        logic        ctrl_w;
        if (!reset_n) return;
        mmio = (address[31:16] == 16'hFFFF);
        if (mem_write && address[31:16] == 16'h0000)
            m_mem[int'((address >> 2) % DEPTH)] = write_data;
        if (mem_write && mmio && address[7:0] == 8'h00)
            m_gpio = write_data;
`ifdef DMEM_TIMER_EN
        match  = m_en && (m_count == m_cmp);
        cmp_w  = mem_write && mmio && address[7:0] == 8'h08;
        ctrl_w = mem_write && mmio && address[7:0] == 8'h0C;
        if (match) m_flag = 1'b1;
        else if (ctrl_w && write_data[1]) m_flag = 1'b0;
        if (cmp_w || match) m_count = '0;
        else if (m_en) m_count = m_count + 1;
        if (cmp_w) m_cmp = write_data;
        if (ctrl_w) m_en = write_data[0];
`else
        match  = 1'b0;
        cmp_w  = 1'b0;
        ctrl_w = 1'b0;
`endif
        m_cycle = m_cycle + 1;
    endtask

    // One bus cycle: drive, check the load, clock it, check the registered outputs.
    task automatic step(input logic we, input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] v;
        mem_write  = we;
        address    = a;
        write_data = wd;
        #1;
        if (exp_read(a, v)) check("read", read_data, v);
        @(posedge clock);
        model_edge();
        #1;
        check("gpio", gpio_out, m_gpio);
        check("irq", {31'b0, timer_irq}, {31'b0, exp_irq()});
    endtask

    task automatic probe(input string tag, input logic [31:0] a, input logic [31:0] exp);
        mem_write = 1'b0;
        address   = a;
        #1;
        check(tag, read_data, exp);
    endtask

    initial begin
        logic        we;
        logic [31:0] a;
        logic [31:0] wd;
        logic [7:0]  ofs;
        int          sel;

        reset_n    = 1'b0;
        mem_write  = 1'b0;
        address    = 32'hFFFF_0004;
        write_data = '0;
        model_reset();
        #2;
        check("rst_gpio", gpio_out, 32'h0);
        check("rst_irq", {31'b0, timer_irq}, 32'h0);
        check("rst_cycle", read_data, 32'h0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // RAM store, byte-offset ignore and aliasing.
        step(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        probe("ram_rd", 32'h0000_0010, 32'hDEAD_BEEF);
        probe("ram_byteofs", 32'h0000_0013, 32'hDEAD_BEEF);
        probe("ram_alias", 32'h0000_0410, 32'hDEAD_BEEF);
        step(1'b1, 32'h0000_0020, 32'h1111_1111);
        // Same-cycle read of a location being written returns the old value.
        step(1'b1, 32'h0000_0020, 32'h3333_3333);
        probe("ram_new", 32'h0000_0020, 32'h3333_3333);
        step(1'b1, 32'h0000_0020, 32'h1111_1111);

        // GPIO store, dropped CYCLE store, unmapped store.
        step(1'b1, 32'hFFFF_0000, 32'h0000_00A5);
        check("gpio_store", gpio_out, 32'h0000_00A5);
        step(1'b1, 32'hFFFF_0004, 32'h0);
        step(1'b0, 32'hFFFF_0004, 32'h0);
        step(1'b0, 32'hFFFF_0004, 32'h0);
        step(1'b1, 32'h1234_0010, 32'hFFFF_FFFF);
        probe("unmapped", 32'h1234_0010, 32'h0);
        probe("ram_kept", 32'h0000_0010, 32'hDEAD_BEEF);

`ifdef DMEM_TIMER_EN
        // irq rises 4 edges after EN is written with CMP = 3.
        step(1'b1, 32'hFFFF_0008, 32'd3);
        step(1'b1, 32'hFFFF_000C, 32'd1);
        for (int k = 1; k <= 4; k++) begin
            step(1'b0, 32'h0000_0010, 32'h0);
            check($sformatf("irq_rise_%0d", k), {31'b0, timer_irq}, {31'b0, k == 4});
        end
        step(1'b1, 32'hFFFF_000C, 32'd3);
        check("irq_w1c", {31'b0, timer_irq}, 32'h0);
        for (int k = 1; k <= 3; k++) begin
            step(1'b0, 32'hFFFF_000C, 32'h0);
            check($sformatf("irq_next_%0d", k), {31'b0, timer_irq}, {31'b0, k == 3});
        end
        for (int k = 0; k < 3; k++) step(1'b0, 32'hFFFF_0008, 32'h0);
        // This W1C lands in the match cycle; the hardware set wins.
        step(1'b1, 32'hFFFF_000C, 32'd3);
        check("set_beats_clr", {31'b0, timer_irq}, 32'h1);
`else
        step(1'b1, 32'hFFFF_0008, 32'd5);
        probe("tcmp_absent", 32'hFFFF_0008, 32'h0);
        for (int k = 0; k < 100; k++) begin
            step(1'b0, 32'hFFFF_000C, 32'h0);
            check("irq_absent", {31'b0, timer_irq}, 32'h0);
        end
`endif

        // Asynchronous reset mid-cycle, with a store pending that must be lost.
        mem_write  = 1'b1;
        address    = 32'h0000_0020;
        write_data = 32'h2222_2222;
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("arst_gpio", gpio_out, 32'h0);
        check("arst_irq", {31'b0, timer_irq}, 32'h0);
        @(posedge clock);
        #1;
        check("arst_store_lost", read_data, 32'h1111_1111);
        mem_write = 1'b0;
        reset_n   = 1'b1;
        probe("arst_ram_kept", 32'h0000_0010, 32'hDEAD_BEEF);
        step(1'b0, 32'hFFFF_0004, 32'h0);

        // Random traffic across RAM, MMIO and unmapped space.
        for (int n = 0; n < 400; n++) begin
            sel = int'($urandom_range(0, 8));
            we  = 1'($urandom_range(0, 1));
            wd  = $urandom;
            if (sel <= 3) begin
                a = {16'h0000, 16'($urandom)};
                a[9:2] = 8'($urandom_range(0, 15));
            end else if (sel <= 7) begin
                case ($urandom_range(0, 5))
                    0: ofs = 8'h00;
                    1: ofs = 8'h04;
                    2: ofs = 8'h08;
                    3: ofs = 8'h0C;
                    4: ofs = 8'h10;
                    default: ofs = 8'hFC;
                endcase
                a = {16'hFFFF, 8'($urandom), ofs};
                if (ofs == 8'h08) wd = $urandom_range(0, 6);
                if (ofs == 8'h0C && $urandom_range(0, 3) != 0) wd[0] = 1'b1;
            end else begin
                a = {16'h1234, 16'($urandom)};
            end
            step(we, a, wd);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
